// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Brief    : RISC_TOY fetch front end; sequential prefetch into a small FIFO
//            with first-word-fallthrough head and redirect flush.
// Revision : 1.0  initial release
// ============================================================================
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IREQ,
  output logic [29:0] IADDR,
  input  logic [31:0] INSTR,
  input  logic        REDIRECT,
  input  logic [29:0] REDIRECT_PC,
  output logic        OUT_VALID,
  output logic [31:0] OUT_INSTR,
  output logic [29:0] OUT_PC,
  input  logic        OUT_READY
);

  localparam int              c_aw    = $clog2(DEPTH);
  localparam int              c_cw    = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  logic [29:0]     r_fetch_pc;
  logic            r_inflight;
  logic [29:0]     r_inflight_pc;
  logic [31:0]     r_mem_instr [DEPTH];
  logic [29:0]     r_mem_pc    [DEPTH];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_cw-1:0] r_count;

  logic [c_cw-1:0] w_occ;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic            w_unused;

  // Low address bits of a redirect target are dropped.
  assign w_unused  = ^REDIRECT_PC[1:0];

  assign OUT_VALID = ~RST & (r_count != '0);
  assign OUT_INSTR = OUT_VALID ? r_mem_instr[r_rptr] : 32'h0;
  assign OUT_PC    = OUT_VALID ? r_mem_pc[r_rptr]    : 30'h0;

  assign w_pop  = OUT_VALID & OUT_READY & ~REDIRECT;
  assign w_push = r_inflight & ~REDIRECT;
  assign w_occ  = r_count + c_cw'(r_inflight);

  // A same-cycle pop frees the slot, keeping 1/cycle throughput when full.
  assign w_issue = ~RST & ~REDIRECT &
                   ((w_occ < c_depth) | ((w_occ == c_depth) & w_pop));

  assign IREQ  = w_issue;
  assign IADDR = RST ? RESET_PC : r_fetch_pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 30'h0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else if (REDIRECT) begin
      r_fetch_pc <= {REDIRECT_PC[29:2], 2'b00};
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 30'd4;
      end
      if (w_push) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_aw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity lives in the pointers/count.
  always_ff @(posedge CLK) begin
    if (~RST & w_push) begin
      r_mem_instr[r_wptr] <= INSTR;
      r_mem_pc[r_wptr]    <= r_inflight_pc;
    end
  end

endmodule
`default_nettype wire
